// File: rtl/noc_local_ni.sv
// noc_local_ni: PE <-> mesh router local-port network interface (TX packer, RX FWFT FIFO).
// Optional statistics counters are built only when NI_STATS_EN is defined.
module noc_local_ni #(
   parameter logic [3:0] NODE_ID   = 4'h5,
   parameter int         DATASIZE  = 40,
   parameter int         WIDTH     = 3,
   parameter int         TX_THRESH = 8,
   parameter int         RX_DEPTH  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pe_tx_valid,
   output logic                pe_tx_ready,
   input  logic [3:0]          pe_tx_dst,
   input  logic [21:0]         pe_tx_data,
   input  logic [1:0]          pe_tx_type,
   output logic [DATASIZE-1:0] net_data_out,
   output logic                net_valid_out,
   input  logic                net_full_in,
   input  logic [WIDTH:0]      net_pressure_in,
   input  logic [DATASIZE-1:0] net_data_in,
   input  logic                net_valid_in,
   output logic                pe_rx_valid,
   input  logic                pe_rx_ready,
   output logic [3:0]          pe_rx_src,
   output logic [21:0]         pe_rx_data,
   output logic [1:0]          pe_rx_type,
   output logic [7:0]          pe_rx_latency,
   output logic [7:0]          rx_drop_cnt,
   output logic [7:0]          misroute_cnt,
   output logic [15:0]         stat_tx_cnt,
   output logic [15:0]         stat_rx_cnt,
   output logic [7:0]          stat_lat_max
);
   localparam int AW = $clog2(RX_DEPTH);
   typedef enum logic {IDLE, SEND} state_t;
   state_t              r_state;
   logic [7:0]          r_ts;
   logic [DATASIZE-1:0] r_tx;
   logic [35:0]         r_mem [RX_DEPTH];
   logic [AW-1:0]       r_wp, r_rp;
   logic [AW:0]         r_cnt;
   logic [7:0]          r_drop, r_mis;
   logic                w_xfer, w_acc, w_hit, w_mis, w_push, w_pop, w_full, w_rxv;
   logic [7:0]          w_lat;

   assign w_xfer        = (r_state == SEND) & ~net_full_in & (int'(net_pressure_in) < TX_THRESH);
   assign pe_tx_ready   = (r_state == IDLE) | w_xfer;
   assign w_acc         = pe_tx_valid & pe_tx_ready;
   assign net_valid_out = w_xfer & ~rst;
   assign net_data_out  = r_tx;
   assign w_rxv         = (r_cnt != '0) & ~rst;
   assign pe_rx_valid   = w_rxv;
   assign w_pop         = w_rxv & pe_rx_ready;
   assign w_full        = r_cnt == (AW+1)'(RX_DEPTH);
   assign w_hit         = net_valid_in & (net_data_in[35:32] == NODE_ID);
   assign w_mis         = net_valid_in & (net_data_in[35:32] != NODE_ID);
   // a full FIFO still accepts when the head leaves in the same cycle
   assign w_push        = w_hit & (~w_full | w_pop);
   assign w_lat         = r_ts - net_data_in[31:24];
   assign {pe_rx_src, pe_rx_data, pe_rx_type, pe_rx_latency} = r_mem[r_rp];
   assign rx_drop_cnt   = r_drop;
   assign misroute_cnt  = r_mis;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ts    <= '0;
         r_tx    <= '0;
      end else begin
         r_ts <= r_ts + 8'd1;
         if (w_acc) begin
            r_tx    <= {NODE_ID, pe_tx_dst, r_ts, pe_tx_data, pe_tx_type};
            r_state <= SEND;
         end else if (w_xfer) r_state <= IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RX_DEPTH; i++) r_mem[i] <= '0;
         r_wp   <= '0;
         r_rp   <= '0;
         r_cnt  <= '0;
         r_drop <= '0;
         r_mis  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wp] <= {net_data_in[39:36], net_data_in[23:2], net_data_in[1:0], w_lat};
            r_wp        <= r_wp + AW'(1);
         end
         if (w_pop) r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
         if (w_hit && !w_push && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
         if (w_mis && r_mis != 8'hFF) r_mis <= r_mis + 8'd1;
      end
   end

`ifdef NI_STATS_EN
   logic [15:0] r_stx, r_srx;
   logic [7:0]  r_lmax;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stx  <= '0;
         r_srx  <= '0;
         r_lmax <= '0;
      end else begin
         if (w_xfer && r_stx != 16'hFFFF) r_stx <= r_stx + 16'd1;
         if (w_push && r_srx != 16'hFFFF) r_srx <= r_srx + 16'd1;
         if (w_push && w_lat > r_lmax) r_lmax <= w_lat;
      end
   end
   assign stat_tx_cnt  = r_stx;
   assign stat_rx_cnt  = r_srx;
   assign stat_lat_max = r_lmax;
`else
   assign stat_tx_cnt  = '0;
   assign stat_rx_cnt  = '0;
   assign stat_lat_max = '0;
`endif
endmodule

// File: tb/tb_noc_local_ni.sv
// tb_noc_local_ni: directed bench with TX/RX scoreboards for noc_local_ni.
module tb_noc_local_ni;
   logic        clk = 1'b0, rst = 1'b1;
   logic        pe_tx_valid, pe_tx_ready, net_valid_out, net_full_in, net_valid_in;
   logic        pe_rx_valid, pe_rx_ready;
   logic [3:0]  pe_tx_dst, pe_rx_src, net_pressure_in;
   logic [21:0] pe_tx_data, pe_rx_data;
   logic [1:0]  pe_tx_type, pe_rx_type;
   logic [39:0] net_data_out, net_data_in;
   logic [7:0]  pe_rx_latency, rx_drop_cnt, misroute_cnt, stat_lat_max;
   logic [15:0] stat_tx_cnt, stat_rx_cnt;
   int          n_assert = 0, n_fail = 0, m_tx = 0, m_rx = 0;
   logic [7:0]  m_ts, m_lmax = 8'd0;
   logic [39:0] txq[$];
   logic [35:0] rxq[$];
   logic [39:0] exp_flit;

   always #5 clk = ~clk;
   always @(posedge clk) m_ts <= rst ? 8'd0 : m_ts + 8'd1;

   noc_local_ni dut (
      .clk(clk), .rst(rst),
      .pe_tx_valid(pe_tx_valid), .pe_tx_ready(pe_tx_ready), .pe_tx_dst(pe_tx_dst),
      .pe_tx_data(pe_tx_data), .pe_tx_type(pe_tx_type),
      .net_data_out(net_data_out), .net_valid_out(net_valid_out), .net_full_in(net_full_in),
      .net_pressure_in(net_pressure_in), .net_data_in(net_data_in), .net_valid_in(net_valid_in),
      .pe_rx_valid(pe_rx_valid), .pe_rx_ready(pe_rx_ready), .pe_rx_src(pe_rx_src),
      .pe_rx_data(pe_rx_data), .pe_rx_type(pe_rx_type), .pe_rx_latency(pe_rx_latency),
      .rx_drop_cnt(rx_drop_cnt), .misroute_cnt(misroute_cnt),
      .stat_tx_cnt(stat_tx_cnt), .stat_rx_cnt(stat_rx_cnt), .stat_lat_max(stat_lat_max)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic mid;
      @(negedge clk);
   endtask

   task automatic send(input logic [3:0] dst, input logic [21:0] d, input logic [1:0] t);
      pe_tx_valid = 1'b1;
      pe_tx_dst   = dst;
      pe_tx_data  = d;
      pe_tx_type  = t;
      txq.push_back({4'h5, dst, m_ts, d, t});
      m_tx++;
   endtask

   task automatic rxflit(input logic [3:0] src, input logic [3:0] dst, input logic [7:0] ts,
                         input logic [21:0] d, input logic [1:0] t, input bit keep);
      logic [7:0] l;
      l = m_ts - ts;
      net_valid_in = 1'b1;
      net_data_in  = {src, dst, ts, d, t};
      if (keep) begin
         rxq.push_back({src, d, t, l});
         m_rx++;
         if (l > m_lmax) m_lmax = l;
      end
   endtask

   task automatic chk_stats(input string tag, input bit zero);
`ifdef NI_STATS_EN
      chk({tag, "_stat_tx"}, stat_tx_cnt, zero ? 0 : m_tx);
      chk({tag, "_stat_rx"}, stat_rx_cnt, zero ? 0 : m_rx);
      chk({tag, "_stat_lat"}, stat_lat_max, zero ? 8'd0 : m_lmax);
`else
      chk({tag, "_stat_tx"}, stat_tx_cnt, 0);
      chk({tag, "_stat_rx"}, stat_rx_cnt, 0);
      chk({tag, "_stat_lat"}, stat_lat_max, 0);
`endif
   endtask

   always @(negedge clk) begin
      if (!rst && net_valid_out) begin
         chk("tx_q_nonempty", txq.size() > 0, 1);
         if (txq.size() > 0) chk("tx_flit", net_data_out, txq.pop_front());
      end
      if (!rst && pe_rx_valid && pe_rx_ready) begin
         chk("rx_q_nonempty", rxq.size() > 0, 1);
         if (rxq.size() > 0) chk("rx_entry", {pe_rx_src, pe_rx_data, pe_rx_type, pe_rx_latency}, rxq.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      pe_tx_valid = 0; pe_tx_dst = 0; pe_tx_data = 0; pe_tx_type = 0;
      net_full_in = 0; net_pressure_in = 0; net_data_in = 0; net_valid_in = 0; pe_rx_ready = 0;
      nxt; mid;
      chk("rst_net_valid", net_valid_out, 0);
      chk("rst_rx_valid", pe_rx_valid, 0);
      nxt; rst = 0; mid;
      chk("post_rst_ready", pe_tx_ready, 1);
      chk("post_rst_net_valid", net_valid_out, 0);
      chk("post_rst_drop", rx_drop_cnt, 0);
      chk("post_rst_mis", misroute_cnt, 0);
      chk_stats("post_rst", 1);
      // basic injection at ts 0x10
      while (m_ts != 8'h10) nxt;
      send(4'h9, 22'h1ABCD, 2'd2);
      mid; chk("idle_ready", pe_tx_ready, 1);
      nxt; pe_tx_valid = 0;
      mid; chk("basic_valid", net_valid_out, 1);
      chk("basic_flit", net_data_out, 40'h5910_06AF36);
      nxt; mid; chk("basic_idle", net_valid_out, 0);
      // stall on full
      nxt; net_full_in = 1; send(4'h2, 22'h2A5A5, 2'd1); exp_flit = txq[0];
      mid; nxt; pe_tx_valid = 0;
      for (int i = 0; i < 5; i++) begin
         mid;
         chk("full_stall_valid", net_valid_out, 0);
         chk("full_stall_ready", pe_tx_ready, 0);
         chk("full_stall_hold", net_data_out, exp_flit);
         nxt;
      end
      net_full_in = 0;
      mid; chk("full_release", net_valid_out, 1);
      nxt; mid; chk("full_after", net_valid_out, 0);
      // stall on pressure at threshold, release just below it
      nxt; net_pressure_in = 4'd8; send(4'hC, 22'h0F0F0, 2'd3); exp_flit = txq[0];
      mid; nxt; pe_tx_valid = 0;
      for (int i = 0; i < 5; i++) begin
         mid;
         chk("press_stall_valid", net_valid_out, 0);
         chk("press_stall_ready", pe_tx_ready, 0);
         chk("press_stall_hold", net_data_out, exp_flit);
         nxt;
      end
      net_pressure_in = 4'd7;
      mid; chk("press7_valid", net_valid_out, 1);
      nxt; net_pressure_in = 0;
      // back-to-back injection
      for (int k = 0; k < 5; k++) begin
         if (k < 4) send(4'(k + 1), 22'($urandom), 2'(k));
         else pe_tx_valid = 0;
         mid;
         if (k < 4) chk("b2b_ready", pe_tx_ready, 1);
         if (k > 0) chk("b2b_valid", net_valid_out, 1);
         nxt;
      end
      mid; chk("b2b_end", net_valid_out, 0);
      // RX latency with timestamp wrap
      while (m_ts != 8'h03) nxt;
      rxflit(4'hA, 4'h5, 8'hFE, 22'h31234, 2'd1, 1);
      mid; chk("rx_not_yet", pe_rx_valid, 0);
      nxt; net_valid_in = 0;
      mid;
      chk("rx_valid", pe_rx_valid, 1);
      chk("rx_latency", pe_rx_latency, 5);
      chk("rx_src", pe_rx_src, 4'hA);
      nxt; pe_rx_ready = 1;
      mid; nxt; pe_rx_ready = 0;
      mid; chk("rx_drained", pe_rx_valid, 0);
      // overflow: 6 flits into a 4-deep FIFO
      nxt;
      for (int k = 0; k < 6; k++) begin
         rxflit(4'(k), 4'h5, 8'($urandom), 22'($urandom), 2'(k), k < 4);
         mid; nxt;
      end
      net_valid_in = 0;
      mid;
      chk("ovf_drop", rx_drop_cnt, 2);
      chk("ovf_valid", pe_rx_valid, 1);
      chk("ovf_mis", misroute_cnt, 0);
      nxt; rxflit(4'h1, 4'h3, 8'h00, 22'h3FFFF, 2'd0, 0);
      mid; nxt; net_valid_in = 0;
      mid;
      chk("mis_cnt", misroute_cnt, 1);
      chk("mis_drop", rx_drop_cnt, 2);
      chk("mis_head", pe_rx_src, 4'h0);
      // push into full FIFO with simultaneous pop
      nxt; pe_rx_ready = 1; rxflit(4'h7, 4'h5, 8'($urandom), 22'h15555, 2'd2, 1);
      mid; nxt; net_valid_in = 0;
      mid; chk("full_pop_drop", rx_drop_cnt, 2);
      repeat (3) begin nxt; mid; end
      nxt; pe_rx_ready = 0;
      mid;
      chk("drain_empty", pe_rx_valid, 0);
      chk("rxq_empty", rxq.size(), 0);
      chk_stats("pre_rst", 0);
      // reset with a flit staged and 3 RX entries held
      nxt; net_full_in = 1;
      pe_tx_valid = 1; pe_tx_dst = 4'h6; pe_tx_data = 22'h12345; pe_tx_type = 2'd0;
      rxflit(4'h2, 4'h5, 8'h00, 22'h1, 2'd0, 0);
      mid; nxt; pe_tx_valid = 0; rxflit(4'h3, 4'h5, 8'h00, 22'h2, 2'd0, 0);
      mid; nxt; rxflit(4'h4, 4'h5, 8'h00, 22'h3, 2'd0, 0);
      mid; nxt; net_valid_in = 0;
      mid; chk("pre_rst_rx_valid", pe_rx_valid, 1);
      nxt; net_full_in = 0; rst = 1;
      mid;
      chk("mid_rst_net_valid", net_valid_out, 0);
      chk("mid_rst_rx_valid", pe_rx_valid, 0);
      nxt; rst = 0;
      mid;
      chk("after_rst_net_valid", net_valid_out, 0);
      chk("after_rst_rx_valid", pe_rx_valid, 0);
      chk("after_rst_drop", rx_drop_cnt, 0);
      chk("after_rst_mis", misroute_cnt, 0);
      chk("after_rst_ready", pe_tx_ready, 1);
      chk_stats("after_rst", 1);
      nxt; mid;
      chk("after_rst2_net_valid", net_valid_out, 0);
      chk("txq_empty", txq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/noc_local_ni.md
Name: noc_local_ni

Overview:
- Network interface between a processing element (PE) and the local (L) port of a mesh router.
- Injection: packs PE messages into 40-bit flits and drives the router's L input. Respects router full and pressure.
- Ejection: accepts flits from the router's L output into a small RX FIFO. Checks the destination, stamps network latency and hands each flit to the PE over a valid/ready handshake.
- Flit format: src[39:36], dst[35:32], timestamp[31:24], data[23:2], type[1:0].

Parameters:
- NODE_ID, 4'h5, this node's address; inserted as src, checked against dst.
- DATASIZE, 40, flit width; fixed format above.
- WIDTH, 3, router pressure is WIDTH+1 bits.
- TX_THRESH, 8, injection inhibited while net_pressure_in >= TX_THRESH.
- RX_DEPTH, 4, RX FIFO entries; power of two.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pe_tx_valid  in  1  PE offers a message.
- pe_tx_ready  out  1  NI accepts the message this cycle.
- pe_tx_dst  in  4  destination node.
- pe_tx_data  in  22  payload.
- pe_tx_type  in  2  packet type, passed through.
- net_data_out  out  40  flit to router L data input.
- net_valid_out  out  1  flit to router L valid input.
- net_full_in  in  1  router L FIFO full.
- net_pressure_in  in  WIDTH+1  router L FIFO occupancy.
- net_data_in  in  40  flit from router L data output.
- net_valid_in  in  1  router L valid output; no backpressure toward router.
- pe_rx_valid  out  1  RX head valid.
- pe_rx_ready  in  1  PE consumes the head.
- pe_rx_src  out  4  head source field.
- pe_rx_data  out  22  head payload.
- pe_rx_type  out  2  head type.
- pe_rx_latency  out  8  head latency in cycles, mod 256.
- rx_drop_cnt  out  8  flits dropped because the RX FIFO was full; saturates at 255.
- misroute_cnt  out  8  flits with dst != NODE_ID; saturates at 255.
- stat_tx_cnt  out  16  see Optional Feature.
- stat_rx_cnt  out  16  see Optional Feature.
- stat_lat_max  out  8  see Optional Feature.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. All registers clear to 0, TX state is IDLE, RX FIFO is empty.
- Output gating during reset: net_valid_out and pe_rx_valid are forced to 0 while rst=1.
- Timestamp counter ts_cnt: 8 bits, +1 every cycle, wraps 255->0.
- TX FSM, IDLE: pe_tx_ready=1.
  - On pe_tx_valid, load tx_reg={NODE_ID, pe_tx_dst, ts_cnt, pe_tx_data, pe_tx_type} and go to SEND.
- TX FSM, SEND:
  - net_valid_out = ~net_full_in & (net_pressure_in < TX_THRESH); the flit transfers in any cycle where net_valid_out=1.
  - pe_tx_ready equals the transfer condition.
  - Transfer with pe_tx_valid=1: load the new flit and stay in SEND (back-to-back, 1 flit/cycle).
  - Transfer without pe_tx_valid: go to IDLE.
  - No transfer: hold tx_reg unchanged for an unbounded number of cycles.
- net_data_out always equals tx_reg. Timestamp is ts_cnt at PE acceptance.
- A message with dst == NODE_ID is legal; it is injected normally.
- RX on net_valid_in=1:
  - If net_data_in[35:32] != NODE_ID: discard and increment misroute_cnt.
  - Else if the FIFO is full and no pop occurs this cycle: discard and increment rx_drop_cnt.
  - Else push {src, data, type, latency = ts_cnt - timestamp (8-bit wrap)}.
  - Push to a full FIFO with a simultaneous pop succeeds.
- RX FIFO is first-word fall-through: pe_rx_* reflect the head, pe_rx_valid = ~empty, pop on pe_rx_valid & pe_rx_ready. Pop when empty is ignored.
- Push to an empty FIFO: visible on pe_rx_valid the next cycle (1-cycle ejection latency).
- Counters saturate at 255 and never wrap.

Optional Feature:
- Macro NI_STATS_EN.
- Defined:
  - stat_tx_cnt increments on each net transfer.
  - stat_rx_cnt increments on each successful RX push.
  - stat_lat_max holds the maximum pushed latency.
  - The 16-bit counters saturate at 16'hFFFF; all three clear on rst.
- Undefined: all three ports are tied to 0 and no registers are built.

Test Plan:
- Basic injection: NODE_ID=5, TX_THRESH=8, net_full_in=0, pressure=0; send dst=9, data=22'h1ABCD, type=2, ts_cnt=0x10 at acceptance -> net_valid_out=1 the next cycle, net_data_out=40'h5910_06AF36 (src 5, dst 9, ts 0x10, data 22'h1ABCD, type 2).
- Stall and resume: hold net_full_in=1 for 5 cycles with the flit staged -> net_valid_out=0 and pe_tx_ready=0 throughout, tx_reg unchanged. Release -> 1 transfer. Repeat with pressure=8 and full=0 -> same stall.
- Back-to-back: pe_tx_valid held high for 4 messages, router not full -> 4 consecutive net_valid_out cycles with no bubbles.
- RX latency: inject flit dst=5, timestamp 0xFE at ts_cnt=0x03 -> pe_rx_valid the next cycle, pe_rx_latency=5.
- RX overflow and misroute: pe_rx_ready=0, push 6 flits to dst=5 -> 4 held, rx_drop_cnt=2. One flit to dst=3 -> misroute_cnt=1, FIFO unchanged. Push while full with pe_rx_ready=1 -> accepted, rx_drop_cnt stays 2.
- Reset mid-operation: assert rst with a flit staged and 3 RX entries held -> net_valid_out=0 and pe_rx_valid=0 during reset and after, all counters 0. With NI_STATS_EN, stat_* also read 0.
